washer_resource_arb: RTL and testbench

//  Round-robin arbiter that shares one mains water inlet valve and one drain

---
 rtl/washer_resource_arb_if.sv | 24 ++
 rtl/washer_resource_arb.sv | 209 ++++++++++++++++++++
 tb/tb_washer_resource_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/washer_resource_arb_if.sv
// Bundle of per-washer request, grant and fault signals shared between the
// washer controllers (master side) and the resource arbiter (slave side).
interface washer_resource_arb_if #(
  parameter int N_WASHERS = 4
);
  logic [N_WASHERS-1:0] fill_req;
  logic [N_WASHERS-1:0] drain_req;
  logic [N_WASHERS-1:0] fault_clr;
  logic [N_WASHERS-1:0] fill_gnt;
  logic [N_WASHERS-1:0] drain_gnt;
  logic                 valve_open;
  logic                 pump_on;
  logic [N_WASHERS-1:0] timeout_flt;

  modport master (
    output fill_req, drain_req, fault_clr,
    input  fill_gnt, drain_gnt, valve_open, pump_on, timeout_flt
  );

  modport slave (
    input  fill_req, drain_req, fault_clr,
    output fill_gnt, drain_gnt, valve_open, pump_on, timeout_flt
  );
endinterface

// File: rtl/washer_resource_arb.sv
// Round-robin arbiter sharing one inlet valve and one drain pump between a
// bank of washers: one independent grant channel per resource, shared fault flags.

module washer_arb_channel #(
  parameter int N       = 4,
  parameter int T_MAX   = 64,
  parameter int T_GUARD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] blocked,
  output logic [N-1:0] gnt,
  output logic         active,
  output logic [N-1:0] tmo_set
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(T_MAX + 1);
  localparam int GW = $clog2(T_GUARD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(T_MAX);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1'b1);
  localparam logic [GW-1:0] GUARD_LEN = GW'(T_GUARD);
  localparam logic [GW-1:0] GUARD_ONE = GW'(1'b1);
  localparam logic [IW-1:0] PTR_INIT  = IW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0  = N'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] ptr_r, ptr_s;
  logic [HW-1:0] hold_r, hold_s;
  logic [GW-1:0] guard_r, guard_s;
  logic [N-1:0]  gnt_r, gnt_s;
  logic          active_r;
  logic [N-1:0]  set_s;
  logic [N-1:0]  eligible_s;
  logic [IW-1:0] pick_s;

  // First eligible requester strictly after ptr, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] elig,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    logic [IW-1:0] idx;
    logic          found;
    sel   = ptr;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Next-state, grant and timeout-pulse logic for one channel.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    hold_s     = hold_r;
    guard_s    = guard_r;
    gnt_s      = gnt_r;
    set_s      = '0;
    eligible_s = req & ~blocked;
    pick_s     = rr_pick(eligible_s, ptr_r);
    case (state_r)
      ST_IDLE: begin
        if (eligible_s != '0) begin
          gnt_s   = ONE_HOT0 << pick_s;
          ptr_s   = pick_s;
          hold_s  = HOLD_ONE;
          state_s = ST_GRANT;
        end else begin
          gnt_s = '0;
        end
      end
      ST_GRANT: begin
        if (!req[ptr_r]) begin
          gnt_s   = '0;
          guard_s = GUARD_ONE;
          state_s = ST_GUARD;
        end else if (hold_r == HOLD_MAX) begin
          gnt_s   = '0;
          set_s   = ONE_HOT0 << ptr_r;
          guard_s = GUARD_ONE;
          state_s = ST_GUARD;
        end else begin
          hold_s = hold_r + HOLD_ONE;
        end
      end
      ST_GUARD: begin
        gnt_s = '0;
        if (guard_r == GUARD_LEN) begin
          guard_s = '0;
          state_s = ST_IDLE;
        end else begin
          guard_s = guard_r + GUARD_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ptr_s   = PTR_INIT;
        hold_s  = '0;
        guard_s = '0;
        gnt_s   = '0;
      end
    endcase
  end

  // Channel state register; reset drops any grant on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ptr_r    <= PTR_INIT;
      hold_r   <= '0;
      guard_r  <= '0;
      gnt_r    <= '0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      hold_r   <= hold_s;
      guard_r  <= guard_s;
      gnt_r    <= gnt_s;
      active_r <= |gnt_s;
    end
  end

  assign gnt     = gnt_r;
  assign active  = active_r;
  assign tmo_set = set_s;
endmodule

module washer_resource_arb_chk #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rst,
  input logic [N-1:0] fill_gnt,
  input logic [N-1:0] drain_gnt,
  input logic         valve_open,
  input logic         pump_on
);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    ($onehot0(fill_gnt) && $onehot0(drain_gnt)));

  a_drive_match: assert property (@(posedge clk) disable iff (rst)
    ((valve_open == (|fill_gnt)) && (pump_on == (|drain_gnt))));
endmodule

module washer_resource_arb #(
  parameter int N_WASHERS   = 4,
  parameter int T_MAX_FILL  = 64,
  parameter int T_MAX_DRAIN = 64,
  parameter int T_GUARD     = 2
) (
  input logic                  clk,
  input logic                  rst,
  washer_resource_arb_if.slave bus
);
  logic [N_WASHERS-1:0] fill_gnt_s;
  logic [N_WASHERS-1:0] drain_gnt_s;
  logic                 valve_s;
  logic                 pump_s;
  logic [N_WASHERS-1:0] fill_set_s;
  logic [N_WASHERS-1:0] drain_set_s;
  logic [N_WASHERS-1:0] flt_r;

  washer_arb_channel #(
    .N(N_WASHERS), .T_MAX(T_MAX_FILL), .T_GUARD(T_GUARD)
  ) u_fill (
    .clk(clk), .rst(rst), .req(bus.fill_req), .blocked(flt_r),
    .gnt(fill_gnt_s), .active(valve_s), .tmo_set(fill_set_s)
  );

  washer_arb_channel #(
    .N(N_WASHERS), .T_MAX(T_MAX_DRAIN), .T_GUARD(T_GUARD)
  ) u_drain (
    .clk(clk), .rst(rst), .req(bus.drain_req), .blocked(flt_r),
    .gnt(drain_gnt_s), .active(pump_s), .tmo_set(drain_set_s)
  );

  // Sticky timeout flags: a new timeout beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_r <= '0;
    end else begin
      flt_r <= (flt_r & ~bus.fault_clr) | fill_set_s | drain_set_s;
    end
  end

  assign bus.fill_gnt    = fill_gnt_s;
  assign bus.drain_gnt   = drain_gnt_s;
  assign bus.valve_open  = valve_s;
  assign bus.pump_on     = pump_s;
  assign bus.timeout_flt = flt_r;

  washer_resource_arb_chk #(.N(N_WASHERS)) u_chk (
    .clk(clk), .rst(rst), .fill_gnt(fill_gnt_s), .drain_gnt(drain_gnt_s),
    .valve_open(valve_s), .pump_on(pump_s)
  );
endmodule

// File: tb/tb_washer_resource_arb.sv
// Bench for washer_resource_arb: a timestamp-based ownership model predicts
// every output each cycle; directed scenarios plus randomized traffic.
module tb_washer_resource_arb;
  localparam int N    = 4;
  localparam int TMAX = 64;
  localparam int TG   = 2;

  logic clk = 1'b0;
  logic rst;

  washer_resource_arb_if #(.N_WASHERS(N)) bus ();

  washer_resource_arb #(
    .N_WASHERS(N), .T_MAX_FILL(TMAX), .T_MAX_DRAIN(TMAX), .T_GUARD(TG)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: per channel (0 = fill, 1 = drain) who owns it, for how long,
  // the earliest edge arbitration may happen again, and the last winner.
  int             m_owner[2];
  int             m_held[2];
  int             m_free_at[2];
  int             m_last[2];
  logic [N-1:0]   m_flt;
  int             m_edge = 0;
  bit             primed = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [N-1:0] m_gnt(input int ch);
    logic [N-1:0] g;
    g = '0;
    if (m_owner[ch] >= 0) g[m_owner[ch]] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, m_edge);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_owner[ch]   = -1;
      m_held[ch]    = 0;
      m_free_at[ch] = 0;
      m_last[ch]    = N - 1;
    end
    m_flt = '0;
  endtask

  // Advance the model by one clock edge with the inputs present at that edge.
  task automatic model_step(input logic [N-1:0] f, input logic [N-1:0] d,
                            input logic [N-1:0] c, input logic r);
    logic [N-1:0] sets, req, elig;
    int pick, idx;
    m_edge++;
    if (r) begin
      model_reset();
      return;
    end
    sets = '0;
    for (int ch = 0; ch < 2; ch++) begin
      req = (ch == 0) ? f : d;
      if (m_owner[ch] >= 0) begin
        if (!req[m_owner[ch]] || m_held[ch] == TMAX) begin
          if (req[m_owner[ch]]) sets[m_owner[ch]] = 1'b1;
          m_owner[ch]   = -1;
          m_free_at[ch] = m_edge + TG + 1;
        end else begin
          m_held[ch]++;
        end
      end else if (m_edge >= m_free_at[ch]) begin
        elig = req & ~m_flt;
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last[ch] + k) % N;
          if (pick < 0 && elig[idx]) pick = idx;
        end
        if (pick >= 0) begin
          m_owner[ch] = pick;
          m_last[ch]  = pick;
          m_held[ch]  = 1;
        end
      end
    end
    m_flt = (m_flt & ~c) | sets;
  endtask

  // One cycle: compare DUT against model, then apply the next inputs.
  task automatic cyc(input logic [N-1:0] f, input logic [N-1:0] d,
                     input logic [N-1:0] c, input logic r);
    @(negedge clk);
    if (primed) begin
      check("fill_gnt",    32'(bus.fill_gnt),    32'(m_gnt(0)));
      check("drain_gnt",   32'(bus.drain_gnt),   32'(m_gnt(1)));
      check("valve_open",  32'(bus.valve_open),  32'(|m_gnt(0)));
      check("pump_on",     32'(bus.pump_on),     32'(|m_gnt(1)));
      check("timeout_flt", 32'(bus.timeout_flt), 32'(m_flt));
    end
    rst           = r;
    bus.fill_req  = f;
    bus.drain_req = d;
    bus.fault_clr = c;
    model_step(f, d, c, r);
    primed = 1'b1;
  endtask

  initial begin
    logic [N-1:0] f, d, c, g;
    logic [31:0]  ord;
    logic         r;
    int           q[$];
    int           prev, hi, seen;
    logic [N-1:0] flt_at_clash;

    rst           = 1'b1;
    bus.fill_req  = '0;
    bus.drain_req = '0;
    bus.fault_clr = '0;
    model_reset();

    repeat (3) cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Washer 1 wins first, washer 2 after release plus guard.
    cyc(4'b0110, 4'b0000, 4'b0000, 1'b0);
    check("t1_first", 32'(m_gnt(0)), 32'h2);
    repeat (5) cyc(4'b0110, 4'b0000, 4'b0000, 1'b0);
    check("t1_hold", 32'(m_gnt(0)), 32'h2);
    cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
    cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
    check("t1_guard", 32'(m_gnt(0)), 32'h0);
    cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
    check("t1_next", 32'(m_gnt(0)), 32'h4);

    // Full rotation with 5-cycle holds.
    repeat (2) cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 60; i++) begin
      f = 4'b1111;
      if (m_owner[0] >= 0 && m_held[0] >= 5) f[m_owner[0]] = 1'b0;
      prev = m_owner[0];
      cyc(f, 4'b0000, 4'b0000, 1'b0);
      if (m_owner[0] >= 0 && m_owner[0] != prev) q.push_back(m_owner[0]);
    end
    ord = 32'h0;
    for (int k = 0; k < 5; k++) ord = (ord << 4) | ((k < q.size()) ? 32'(q[k]) : 32'hF);
    check("t2_order", ord, 32'h01230);

    // Hold timeout on washer 3, then masked on both channels.
    repeat (2) cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
      g = m_gnt(0);
      if (g[3]) hi++;
    end
    check("t3_hold_cycles", 32'(hi), 32'd64);
    check("t3_flag", 32'(m_flt), 32'h8);
    repeat (10) cyc(4'b1000, 4'b1000, 4'b0000, 1'b0);
    check("t3_masked", 32'(m_gnt(0) | m_gnt(1)), 32'h0);

    // Clear, then a second timeout coinciding with a clear keeps the flag.
    cyc(4'b0000, 4'b0000, 4'b1000, 1'b0);
    check("t4_clr", 32'(m_flt), 32'h0);
    cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
    seen = 0;
    flt_at_clash = '0;
    for (int i = 0; i < 80; i++) begin
      c = (m_owner[1] == 3 && m_held[1] == TMAX) ? 4'b1000 : 4'b0000;
      cyc(4'b1000, 4'b1000, c, 1'b0);
      if (c != 4'b0000) begin
        seen++;
        flt_at_clash = m_flt;
      end
    end
    check("t4_clash_seen", 32'(seen), 32'd1);
    check("t4_set_wins", 32'(flt_at_clash), 32'h8);
    repeat (4) cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 4'b1000, 1'b0);
    check("t4_clr_alone", 32'(m_flt), 32'h0);
    cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
    check("t4_regrant", 32'(m_gnt(0)), 32'h8);

    // Same washer on both channels.
    repeat (2) cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0001, 4'b0000, 1'b0);
    check("t5_both", 32'({m_gnt(0), m_gnt(1)}), 32'h11);
    repeat (3) cyc(4'b0001, 4'b0001, 4'b0000, 1'b0);

    // Reset mid-grant, then washer 0 wins over washer 2.
    cyc(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check("t6_reset", 32'({m_gnt(0), m_gnt(1), m_flt}), 32'h0);
    cyc(4'b0101, 4'b0000, 4'b0000, 1'b0);
    check("t6_first", 32'(m_gnt(0)), 32'h1);
    repeat (3) cyc(4'b0101, 4'b0000, 4'b0000, 1'b0);

    // Random traffic: busy phase, then slow phase that reaches timeouts.
    f = '0;
    d = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(0, (ph == 0) ? 7 : 99) == 0) f[b] = ~f[b];
          if ($urandom_range(0, (ph == 0) ? 7 : 99) == 0) d[b] = ~d[b];
        end
        c = ($urandom_range(0, 31) == 0) ? N'($urandom_range(0, 15)) : 4'b0000;
        r = ($urandom_range(0, 599) == 0);
        cyc(f, d, c, r);
      end
    end
    cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
